// File: rtl/cmd_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_arbiter
// Arbitrates between a manual and a script command requester and drives the
// granted 8-bit command word onto the game link for HOLD_CYC cycles. A
// non-null operate command is followed by GAP_CYC idle cycles. Manual always
// wins ties; script is only eligible when script_en is set.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   man_valid  : manual command pending
//   man_cmd    : manual command word ([1:0] channel, [7:2] payload)
//   man_ready  : manual command accepted this cycle (combinational)
//   scr_valid  : script command pending
//   scr_cmd    : script command word
//   scr_ready  : script command accepted this cycle (combinational)
//   script_en  : script requester may be granted
//   in_bits    : registered command word to the game link
//   busy       : registered, high during HOLD and GAP
//   grant      : registered owner: 00 none, 01 manual, 10 script
//   cmd_count  : registered count of accepted commands (wraps)
// -----------------------------------------------------------------------------
module cmd_arbiter #(
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       man_valid,
    input  logic [7:0] man_cmd,
    output logic       man_ready,
    input  logic       scr_valid,
    input  logic [7:0] scr_cmd,
    output logic       scr_ready,
    input  logic       script_en,
    output logic [7:0] in_bits,
    output logic       busy,
    output logic [1:0] grant,
    output logic [7:0] cmd_count
);

    localparam logic [7:0] IDLE_WORD = 8'h02;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);
    localparam logic [3:0] GAP_LOAD  = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;
    localparam logic       GAP_EN    = (GAP_CYC > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Operate channel with a non-zero payload earns a trailing gap.
    function automatic logic needs_gap(input logic [7:0] cmd);
        return (cmd[1:0] == 2'b10) && (cmd[7:2] != 6'd0);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] in_bits_q, in_bits_d;
    logic       busy_q, busy_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] count_q, count_d;

    logic       idle_s;
    logic       man_xfer_s;
    logic       scr_xfer_s;
    logic [7:0] sel_cmd_s;

    assign idle_s     = (state_q == S_IDLE);
    assign man_ready  = idle_s;
    assign scr_ready  = idle_s & script_en & ~man_valid;
    assign man_xfer_s = man_valid & man_ready;
    assign scr_xfer_s = scr_valid & scr_ready;
    assign sel_cmd_s  = man_xfer_s ? man_cmd : scr_cmd;

    assign in_bits   = in_bits_q;
    assign busy      = busy_q;
    assign grant     = grant_q;
    assign cmd_count = count_q;

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so the registered values line up with the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        in_bits_d = in_bits_q;
        busy_d    = busy_q;
        grant_d   = grant_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (man_xfer_s || scr_xfer_s) begin
                    state_d   = S_HOLD;
                    cnt_d     = HOLD_LOAD;
                    cmd_d     = sel_cmd_s;
                    in_bits_d = sel_cmd_s;
                    busy_d    = 1'b1;
                    grant_d   = man_xfer_s ? 2'b01 : 2'b10;
                    count_d   = count_q + 8'd1;
                end else begin
                    in_bits_d = IDLE_WORD;
                    busy_d    = 1'b0;
                    grant_d   = 2'b00;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) begin
                    in_bits_d = IDLE_WORD;
                    if (GAP_EN && needs_gap(cmd_q)) begin
                        // Owner stays visible on grant through the gap.
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                        busy_d  = 1'b0;
                        grant_d = 2'b00;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_IDLE;
                    in_bits_d = IDLE_WORD;
                    busy_d    = 1'b0;
                    grant_d   = 2'b00;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = 4'd0;
                in_bits_d = IDLE_WORD;
                busy_d    = 1'b0;
                grant_d   = 2'b00;
            end
        endcase
    end

    // State, timer, latched command and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cmd_q     <= IDLE_WORD;
            in_bits_q <= IDLE_WORD;
            busy_q    <= 1'b0;
            grant_q   <= 2'b00;
            count_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            in_bits_q <= in_bits_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
module tb_cmd_arbiter;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       man_valid, scr_valid, script_en;
    logic [7:0] man_cmd, scr_cmd;
    logic       man_ready, scr_ready;
    logic [7:0] in_bits, cmd_count;
    logic       busy;
    logic [1:0] grant;

    cmd_arbiter #(.HOLD_CYC(HOLD), .GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .man_valid (man_valid),
        .man_cmd   (man_cmd),
        .man_ready (man_ready),
        .scr_valid (scr_valid),
        .scr_cmd   (scr_cmd),
        .scr_ready (scr_ready),
        .script_en (script_en),
        .in_bits   (in_bits),
        .busy      (busy),
        .grant     (grant),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    // Link output expected for one cycle.
    typedef struct {
        logic [7:0] ib;
        logic       bz;
        logic [1:0] gr;
    } out_t;

    // Everything observable in one cycle.
    typedef struct {
        logic [7:0] ib;
        logic       bz;
        logic [1:0] gr;
        logic       mr;
        logic       sr;
        logic [7:0] cnt;
    } rec_t;

    out_t plan[$];      // future busy cycles produced by accepted commands
    rec_t sb[$];        // scoreboard: expected per-cycle observations
    logic [7:0] exp_count;
    int errors = 0;
    int checks = 0;
    rec_t mon_r;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle the DUT is out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sb.size() > 0) begin
            mon_r = sb.pop_front();
            chk("in_bits",   in_bits,           mon_r.ib);
            chk("busy",      {7'd0, busy},      {7'd0, mon_r.bz});
            chk("grant",     {6'd0, grant},     {6'd0, mon_r.gr});
            chk("man_ready", {7'd0, man_ready}, {7'd0, mon_r.mr});
            chk("scr_ready", {7'd0, scr_ready}, {7'd0, mon_r.sr});
            chk("cmd_count", cmd_count,         mon_r.cnt);
        end
    end

    // One cycle of stimulus; the reference model expands each accepted
    // command into its whole HOLD/GAP output sequence.
    task automatic step(input logic mv, input logic [7:0] mc,
                        input logic sv, input logic [7:0] sc, input logic se);
        out_t cur;
        rec_t r;
        logic [7:0] c;
        logic [1:0] own;
        @(posedge clk);
        #1;
        if (plan.size() > 0) cur = plan.pop_front();
        else cur = '{8'h02, 1'b0, 2'b00};
        man_valid = mv; man_cmd = mc;
        scr_valid = sv; scr_cmd = sc;
        script_en = se;
        r.ib = cur.ib; r.bz = cur.bz; r.gr = cur.gr;
        r.mr = ~cur.bz;
        r.sr = ~cur.bz & se & ~mv;
        r.cnt = exp_count;
        sb.push_back(r);
        own = 2'b00;
        c = 8'h00;
        if (!cur.bz && mv) begin
            own = 2'b01; c = mc;
        end else if (!cur.bz && se && sv) begin
            own = 2'b10; c = sc;
        end
        if (own != 2'b00) begin
            exp_count = exp_count + 8'd1;
            for (int i = 0; i < HOLD; i++) plan.push_back('{c, 1'b1, own});
            if (c[1:0] == 2'b10 && c[7:2] != 6'd0)
                for (int i = 0; i < GAP; i++) plan.push_back('{8'h02, 1'b1, own});
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_bits",   in_bits,       8'h02);
        chk("rst_busy",      {7'd0, busy},  8'h00);
        chk("rst_grant",     {6'd0, grant}, 8'h00);
        chk("rst_cmd_count", cmd_count,     8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        man_valid = 1'b0; man_cmd = 8'h00;
        scr_valid = 1'b0; scr_cmd = 8'h00;
        script_en = 1'b0;
        exp_count = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Single manual operate command with gap.
        step(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
        idle_cycles(8);

        // Tie: manual wins, script follows at first idle after manual gap.
        step(1'b1, 8'h0A, 1'b1, 8'h42, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, 8'h42, 1'b1);
        idle_cycles(4);

        // Script disabled: ignored.
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);

        // Target-select word: no gap.
        step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        idle_cycles(6);

        // script_en drop / manual arrival during a script sequence.
        step(1'b0, 8'h00, 1'b1, 8'h86, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h36, 1'b1, 8'h11, 1'b0);
        idle_cycles(12);

        // Reset on second HOLD cycle of 8'h12.
        step(1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        man_valid = 1'b0; scr_valid = 1'b0; script_en = 1'b0;
        plan.delete();
        sb.delete();
        exp_count = 8'h00;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h5E, 1'b0, 8'h00, 1'b0);
        idle_cycles(8);

        // Counter wrap: 256 target-select commands back to back.
        for (int i = 0; i < 256 * (HOLD + 1); i++) step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        idle_cycles(6);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0));
        idle_cycles(10);

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 4, giving the cycles each granted command word is driven on in_bits (legal 1..15).
REQ-002 The block SHALL have parameter GAP_CYC, default 2, giving the idle cycles inserted after a non-null operate command (legal 0..15).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 man_valid  input  1  manual requester has a command pending.
REQ-006 man_cmd  input  8  manual command word: [1:0] channel, [7:2] payload.
REQ-007 man_ready  output  1  manual command accepted this cycle when man_valid=1.
REQ-008 scr_valid  input  1  script requester has a command pending.
REQ-009 scr_cmd  input  8  script command word, same format as man_cmd.
REQ-010 scr_ready  output  1  script command accepted this cycle when scr_valid=1.
REQ-011 script_en  input  1  script requester allowed to be granted.
REQ-012 in_bits  output  8  registered command word to the game link.
REQ-013 busy  output  1  registered; 1 while in HOLD or GAP.
REQ-014 grant  output  2  registered owner of current word: 00 none, 01 manual, 10 script.
REQ-015 cmd_count  output  8  registered count of accepted commands.

Function
REQ-016 States SHALL be IDLE, HOLD, GAP; IDLE_WORD = 8'h02 (operate channel, null payload).
REQ-017 In IDLE, in_bits SHALL be IDLE_WORD, grant 00, busy 0.
REQ-018 man_ready SHALL be combinational: (state==IDLE).
REQ-019 scr_ready SHALL be combinational: (state==IDLE) & script_en & ~man_valid.
REQ-020 A transfer SHALL occur on a cycle where valid & ready; manual wins all ties (strict priority).
REQ-021 With script_en=0, scr_valid SHALL be ignored and scr_ready held 0.
REQ-022 On a transfer at edge t, the command SHALL be latched, state -> HOLD, grant set to owner, cmd_count += 1 (wraps 8'hFF -> 8'h00).
REQ-023 in_bits SHALL equal the latched command for exactly HOLD_CYC cycles, starting the cycle after the transfer.
REQ-024 At HOLD end: if cmd[1:0]==2'b10, cmd[7:2]!=0 and GAP_CYC>0, state -> GAP; else -> IDLE.
REQ-025 In GAP, in_bits SHALL be IDLE_WORD, grant SHALL keep the owner, busy 1, for exactly GAP_CYC cycles, then -> IDLE.
REQ-026 Earliest next transfer SHALL be the first IDLE cycle; back-to-back commands are separated by at least one IDLE cycle.
REQ-027 A 4-bit down-counter SHALL time HOLD and GAP; loaded at state entry, transition on reaching 0.
REQ-028 script_en falling during a script HOLD/GAP SHALL NOT abort it; the sequence completes.
REQ-029 man_valid rising during a script HOLD/GAP SHALL NOT preempt; manual is granted at the next IDLE.
REQ-030 Requester inputs changing after transfer SHALL NOT affect the latched word.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, in_bits 8'h02, busy 0, grant 00, cmd_count 8'h00, counter 0, latched command 8'h02.
REQ-032 Reset asserted mid-HOLD or mid-GAP SHALL abort the command; after release the block sits in IDLE and accepts on the first cycle with valid.

Verification (HOLD_CYC=4, GAP_CYC=2)
REQ-033 man_valid=1, man_cmd=8'h22 one cycle in IDLE -> man_ready=1 that cycle; in_bits=8'h22 4 cycles, 8'h02 2 cycles with busy=1, grant=01; then IDLE, cmd_count=1.
REQ-034 Both valid same cycle, script_en=1, man_cmd=8'h0A, scr_cmd=8'h42 -> scr_ready=0, manual granted; script granted first IDLE cycle after manual GAP, grant=10.
REQ-035 script_en=0, scr_valid=1 for 20 cycles -> scr_ready=0, in_bits=8'h02, cmd_count unchanged.
REQ-036 Target-select man_cmd=8'hFF -> in_bits=8'hFF 4 cycles, no GAP, IDLE the next cycle.
REQ-037 rst_n pulled low on 2nd HOLD cycle of 8'h12 -> in_bits=8'h02, busy=0, grant=00 asynchronously, cmd_count=0.
REQ-038 256 accepted commands -> cmd_count wraps to 8'h00.
